// File: rtl/shift_iter_unit.sv
// Iterative 32-bit shifter: one fixed power-of-two stage per cycle (16,8,4,2,1).
// Define SHIFT_ITER_SRL_EN to enable logical right shift on op 2'b10.
module shift_iter_unit #(
  parameter int unsigned ZERO_BYPASS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_data_in,
  input  logic [4:0]  i_shamt,
  input  logic [1:0]  i_op,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_data_out
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSra = 2'b01;
`ifdef SHIFT_ITER_SRL_EN
  localparam logic [1:0] OpSrl = 2'b10;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_work, w_work_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_shamt, w_shamt_nxt;
  logic [1:0]  r_op, w_op_nxt;

  logic        w_fill;
  logic        w_right_op;
  logic        w_stage_en;
  logic [31:0] w_left;
  logic [31:0] w_right;

`ifdef SHIFT_ITER_SRL_EN
  assign w_fill     = (r_op == OpSra) & r_work[31];
  assign w_right_op = (r_op == OpSra) | (r_op == OpSrl);
`else
  assign w_fill     = r_work[31];
  assign w_right_op = (r_op == OpSra);
`endif

  // Counter 0..4 selects shift by 16,8,4,2,1, gated by shamt bit 4..0.
  always_comb begin
    w_stage_en = 1'b0;
    w_left     = r_work;
    w_right    = r_work;
    case (r_cnt)
      3'd0: begin
        w_stage_en = r_shamt[4];
        w_left     = {r_work[15:0], 16'h0000};
        w_right    = {{16{w_fill}}, r_work[31:16]};
      end
      3'd1: begin
        w_stage_en = r_shamt[3];
        w_left     = {r_work[23:0], 8'h00};
        w_right    = {{8{w_fill}}, r_work[31:8]};
      end
      3'd2: begin
        w_stage_en = r_shamt[2];
        w_left     = {r_work[27:0], 4'h0};
        w_right    = {{4{w_fill}}, r_work[31:4]};
      end
      3'd3: begin
        w_stage_en = r_shamt[1];
        w_left     = {r_work[29:0], 2'b00};
        w_right    = {{2{w_fill}}, r_work[31:2]};
      end
      default: begin
        w_stage_en = r_shamt[0];
        w_left     = {r_work[30:0], 1'b0};
        w_right    = {w_fill, r_work[31:1]};
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_shamt_nxt = r_shamt;
    w_op_nxt    = r_op;
    case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_work_nxt  = i_data_in;
          w_shamt_nxt = i_shamt;
          w_op_nxt    = i_op;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ((ZERO_BYPASS != 0) && (i_shamt == 5'd0)) ? StDone : StShift;
        end
      end
      StShift: begin
        // Reserved ops leave the working register untouched.
        if (w_stage_en) begin
          if (r_op == OpSll) begin
            w_work_nxt = w_left;
          end else if (w_right_op) begin
            w_work_nxt = w_right;
          end
        end
        if (r_cnt == 3'd4) begin
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      StDone: begin
        if (i_out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_work  <= 32'h0;
      r_cnt   <= 3'd0;
      r_shamt <= 5'd0;
      r_op    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shamt <= w_shamt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_data_out  = r_work;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Scoreboard bench for shift_iter_unit; a second instance covers ZERO_BYPASS=0.
module tb_shift_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] data_in, data_out;
  logic [4:0]  shamt;
  logic [1:0]  op;

  logic        nb_in_valid, nb_in_ready, nb_out_valid, nb_out_ready;
  logic [31:0] nb_data_in, nb_data_out;
  logic [4:0]  nb_shamt;
  logic [1:0]  nb_op;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  shift_iter_unit #(.ZERO_BYPASS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_data_in(data_in), .i_shamt(shamt), .i_op(op), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_data_out(data_out)
  );

  shift_iter_unit #(.ZERO_BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(nb_in_valid), .o_in_ready(nb_in_ready),
    .i_data_in(nb_data_in), .i_shamt(nb_shamt), .i_op(nb_op), .o_out_valid(nb_out_valid),
    .i_out_ready(nb_out_ready), .o_data_out(nb_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] o);
    case (o)
      2'b00: return d << s;
      2'b01: return $unsigned($signed(d) >>> s);
`ifdef SHIFT_ITER_SRL_EN
      2'b10: return d >> s;
`endif
      default: return d;
    endcase
  endfunction

  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                        input logic [31:0] exp, input int exp_lat, input int hold,
                        input string name);
    int lat;
    logic [31:0] got, want;
    lat = 0;
    while (in_ready !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_wait: in_ready=%b want 1", name, in_ready);
    end
    in_valid = 1'b1; data_in = d; shamt = s; op = o;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d edges want %0d", name, lat, exp_lat);
    end
    want = sb_q.pop_front();
    total++;
    if (data_out !== want) begin
      bad++; $display("FAIL %s data: got %08h want %08h", name, data_out, want);
    end
    got = data_out;
    repeat (hold) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || data_out !== got || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold: ov=%b rdy=%b data=%08h want ov=1 rdy=0 data=%08h",
                 name, out_valid, in_ready, data_out, got);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release: ov=%b rdy=%b want ov=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %08h want 0", data_out); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(32'h8000_0000, 5'd8, 2'b01, 32'hFF80_0000, 5, 0, "sra8");
    run_op(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 5, 1, "sll31");
    run_op(32'h7FFF_FFFF, 5'd31, 2'b01, 32'h0000_0000, 5, 0, "sra31");
`ifdef SHIFT_ITER_SRL_EN
    run_op(32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000, 5, 0, "op10");
`else
    run_op(32'h8000_0000, 5'd4, 2'b10, 32'h8000_0000, 5, 0, "op10");
`endif
    run_op(32'hDEAD_BEEF, 5'd7, 2'b11, 32'hDEAD_BEEF, 5, 0, "op11");
  endtask

  task automatic test_zero_bypass();
    int lat;
    run_op(32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678, 0, 2, "bypass");
    nb_in_valid = 1'b1; nb_data_in = 32'h1234_5678; nb_shamt = 5'd0; nb_op = 2'b01;
    @(posedge clk); #1;
    nb_in_valid = 1'b0;
    lat = 0;
    while (nb_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL nobypass latency: got %0d want 5", lat); end
    total++;
    if (nb_data_out !== 32'h1234_5678) begin
      bad++; $display("FAIL nobypass data: got %08h want 12345678", nb_data_out);
    end
    nb_out_ready = 1'b1;
    @(posedge clk); #1;
    nb_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] want;
    in_valid = 1'b1; data_in = 32'h0000_00F0; shamt = 5'd4; op = 2'b00;
    sb_q.push_back(32'h0000_0F00);
    @(posedge clk); #1;
    data_in = 32'hAAAA_5555; shamt = 5'd1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    want = sb_q.pop_front();
    total++;
    if (lat !== 5 || data_out !== want) begin
      bad++; $display("FAIL stall_first: lat=%0d data=%08h want 5 %08h", lat, data_out, want);
    end
    repeat (10) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || data_out !== want || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: ov=%b rdy=%b data=%08h want 1 0 %08h",
                 out_valid, in_ready, data_out, want);
      end
    end
    sb_q.push_back(32'h5554_AAAA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_handshake: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_second_accept: rdy=%b want 0", in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    want = sb_q.pop_front();
    total++;
    if (lat !== 5 || data_out !== want) begin
      bad++; $display("FAIL stall_second: lat=%0d data=%08h want 5 %08h", lat, data_out, want);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1; data_in = 32'h8000_0000; shamt = 5'd8; op = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 32'h0) begin
      bad++;
      $display("FAIL abort_reset: rdy=%b ov=%b data=%08h want 1 0 00000000",
               in_ready, out_valid, data_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'h0F0F_0000, 5'd12, 2'b00, 32'hF000_0000, 5, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      s = (i % 6 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      o = 2'($urandom_range(0, 3));
      run_op(d, s, o, model(d, s, o), (s == 5'd0) ? 0 : 5, i % 3, "random");
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; data_in = '0; shamt = '0; op = '0;
    nb_in_valid = 1'b0; nb_out_ready = 1'b0; nb_data_in = '0; nb_shamt = '0; nb_op = '0;
    test_reset();
    test_directed();
    test_zero_bypass();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
